// File: rtl/edic_ctrl_pkg.sv
// Shared types for the control sequencer: opcodes, FSM states and the
// bundled datapath strobe record.
package edic_ctrl_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_SHR  = 4'h6,
    OP_SHL  = 4'h7,
    OP_ST   = 4'h8,
    OP_LD   = 4'h9,
    OP_BZ   = 4'hA,
    OP_BN   = 4'hB,
    OP_RSVC = 4'hC,
    OP_RSVD = 4'hD,
    OP_RSVE = 4'hE,
    OP_HLT  = 4'hF
  } opcode_t;

  typedef enum logic [3:0] {
    IDLE, IMM, BLOAD, EXEC, WB, MADDR, MWR, MRD, BR, ILL, HALT
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_AND   = 2'b01;
  localparam logic [1:0] ALU_OR    = 2'b10;
  localparam logic [1:0] ALU_SHIFT = 2'b11;

  typedef struct packed {
    logic       aluOE;
    logic       aluSub;
    logic       aluBWr;
    logic       aluShiftLeft;
    logic       aluSel;
    logic [1:0] aluOp;
    logic       regWr0;
    logic       regWr1;
    logic       regBusSel;
    logic       regBusEn;
    logic       ramAddressEn;
    logic       ramWriteEn;
    logic       ramReadDataSelect;
    logic       ramOE;
    logic       busImmEn;
  } ctrl_t;

  function automatic logic [1:0] aluOpFor(opcode_t op);
    case (op)
      OP_AND:         return ALU_AND;
      OP_OR:          return ALU_OR;
      OP_SHR, OP_SHL: return ALU_SHIFT;
      default:        return ALU_ADD;
    endcase
  endfunction

  // State entered on the cycle after an instruction is accepted.
  function automatic state_t firstState(opcode_t op);
    case (op)
      OP_NOP:                                       return IDLE;
      OP_LDI:                                       return IMM;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: return BLOAD;
      OP_ST, OP_LD:                                 return MADDR;
      OP_BZ, OP_BN:                                 return BR;
      OP_HLT:                                       return HALT;
      default:                                      return ILL;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_instr_decode.sv
// Combinational strobe decoder: maps the current state and the control
// byte of the instruction register onto the datapath strobes.
module instr_decode
  import edic_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic [7:0] irCtrl,
  output ctrl_t      ctrl
);

  state_t  st;
  opcode_t op;
  logic    rd, ra, useImm, rb;

  assign st     = state_t'(state);
  assign op     = opcode_t'(irCtrl[7:4]);
  assign rd     = irCtrl[3];
  assign ra     = irCtrl[2];
  assign useImm = irCtrl[1];
  assign rb     = irCtrl[0];

  always_comb begin
    ctrl = '0;
    case (st)
      IMM: begin
        ctrl.busImmEn = 1'b1;
        ctrl.regWr0   = ~rd;
        ctrl.regWr1   = rd;
      end
      BLOAD: begin
        ctrl.aluBWr = 1'b1;
        if (useImm) begin
          ctrl.busImmEn = 1'b1;
        end else begin
          ctrl.regBusSel = rb;
          ctrl.regBusEn  = 1'b1;
        end
      end
      EXEC, WB: begin
        ctrl.aluOp        = aluOpFor(op);
        ctrl.aluSub       = (op == OP_SUB);
        ctrl.aluShiftLeft = (op == OP_SHL);
        ctrl.aluSel       = ra;
        if (st == WB) begin
          ctrl.aluOE  = 1'b1;
          ctrl.regWr0 = ~rd;
          ctrl.regWr1 = rd;
        end
      end
      MADDR: begin
        ctrl.regBusSel    = ra;
        ctrl.regBusEn     = 1'b1;
        ctrl.ramAddressEn = 1'b1;
      end
      MWR: begin
        ctrl.regBusSel  = rb;
        ctrl.regBusEn   = 1'b1;
        ctrl.ramWriteEn = 1'b1;
      end
      MRD: begin
        ctrl.ramReadDataSelect = 1'b1;
        ctrl.ramOE             = 1'b1;
        ctrl.regWr0            = ~rd;
        ctrl.regWr1            = rd;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Micro-sequencer: accepts one instruction per handshake, steps the FSM,
// drives datapath strobes and immediates, and resolves N/Z branches.
module control_sequencer
  import edic_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [DATA_WIDTH+7:0]   i_instr,
  input  logic                    i_instrValid,
  output logic                    o_instrReady,
  input  logic                    i_aluFlagN,
  input  logic                    i_aluFlagZ,
  output logic                    o_ctrlAluOE,
  output logic                    o_ctrlAluSub,
  output logic                    o_ctrlAluBWr,
  output logic                    o_ctrlAluShiftLeft,
  output logic                    o_ctrlAluSel,
  output logic [1:0]              o_ctrlAluOp,
  output logic                    o_ctrlRegWr0,
  output logic                    o_ctrlRegWr1,
  output logic                    o_ctrlRegBusSel,
  output logic                    o_ctrlRegBusEn,
  output logic                    o_ctrlRamAddressEn,
  output logic                    o_ctrlRamWriteEn,
  output logic                    o_ctrlRamReadDataSelect,
  output logic                    o_ctrlRamOE,
  output logic [DATA_WIDTH-1:0]   o_busImm,
  output logic                    o_busImmEn,
  output logic                    o_branchValid,
  output logic [DATA_WIDTH-1:0]   o_branchTarget,
  output logic                    o_illegal,
  output logic                    o_halted
);

  state_t                state, stateNext;
  logic [DATA_WIDTH+7:0] ir;
  logic                  flagN, flagZ;
  logic                  accept;
  logic                  branchTaken;
  opcode_t               irOp;
  logic [DATA_WIDTH-1:0] irImm;
  ctrl_t                 ctrl;

  assign irOp   = opcode_t'(ir[DATA_WIDTH+7:DATA_WIDTH+4]);
  assign irImm  = ir[DATA_WIDTH-1:0];
  assign accept = i_instrValid & o_instrReady;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
      ir    <= '0;
      flagN <= 1'b0;
      flagZ <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) ir <= i_instr;
      if (state == WB) begin
        flagN <= i_aluFlagN;
        flagZ <= i_aluFlagZ;
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = firstState(opcode_t'(i_instr[DATA_WIDTH+7:DATA_WIDTH+4]));
      BLOAD:   stateNext = EXEC;
      EXEC:    stateNext = WB;
      MADDR:   stateNext = (irOp == OP_ST) ? MWR : MRD;
      HALT:    stateNext = HALT;
      default: stateNext = IDLE;
    endcase
  end

  instr_decode u_decode (
    .state  (state),
    .irCtrl (ir[DATA_WIDTH+7:DATA_WIDTH]),
    .ctrl   (ctrl)
  );

  // Ready is masked by reset directly so it drops with the async reset edge.
  always_comb begin
    branchTaken             = (state == BR) & ((irOp == OP_BZ) ? flagZ : flagN);
    o_instrReady            = (state == IDLE) & ~i_reset;
    o_ctrlAluOE             = ctrl.aluOE;
    o_ctrlAluSub            = ctrl.aluSub;
    o_ctrlAluBWr            = ctrl.aluBWr;
    o_ctrlAluShiftLeft      = ctrl.aluShiftLeft;
    o_ctrlAluSel            = ctrl.aluSel;
    o_ctrlAluOp             = ctrl.aluOp;
    o_ctrlRegWr0            = ctrl.regWr0;
    o_ctrlRegWr1            = ctrl.regWr1;
    o_ctrlRegBusSel         = ctrl.regBusSel;
    o_ctrlRegBusEn          = ctrl.regBusEn;
    o_ctrlRamAddressEn      = ctrl.ramAddressEn;
    o_ctrlRamWriteEn        = ctrl.ramWriteEn;
    o_ctrlRamReadDataSelect = ctrl.ramReadDataSelect;
    o_ctrlRamOE             = ctrl.ramOE;
    o_busImmEn              = ctrl.busImmEn;
    o_busImm                = ctrl.busImmEn ? irImm : '0;
    o_branchValid           = branchTaken;
    o_branchTarget          = branchTaken ? irImm : '0;
    o_illegal               = (state == ILL);
    o_halted                = (state == HALT);
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven bench for control_sequencer with a per-cycle expected-output
// scoreboard and hand-written reset/halt sequences.
module tb_control_sequencer;

  logic        i_clk, i_reset;
  logic [15:0] i_instr;
  logic        i_instrValid, o_instrReady;
  logic        i_aluFlagN, i_aluFlagZ;
  logic        o_ctrlAluOE, o_ctrlAluSub, o_ctrlAluBWr, o_ctrlAluShiftLeft, o_ctrlAluSel;
  logic [1:0]  o_ctrlAluOp;
  logic        o_ctrlRegWr0, o_ctrlRegWr1, o_ctrlRegBusSel, o_ctrlRegBusEn;
  logic        o_ctrlRamAddressEn, o_ctrlRamWriteEn, o_ctrlRamReadDataSelect, o_ctrlRamOE;
  logic [7:0]  o_busImm;
  logic        o_busImmEn, o_branchValid;
  logic [7:0]  o_branchTarget;
  logic        o_illegal, o_halted;

  int compared = 0;
  int mismatched = 0;

  control_sequencer #(.DATA_WIDTH(8)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_instr(i_instr),
    .i_instrValid(i_instrValid), .o_instrReady(o_instrReady),
    .i_aluFlagN(i_aluFlagN), .i_aluFlagZ(i_aluFlagZ),
    .o_ctrlAluOE(o_ctrlAluOE), .o_ctrlAluSub(o_ctrlAluSub), .o_ctrlAluBWr(o_ctrlAluBWr),
    .o_ctrlAluShiftLeft(o_ctrlAluShiftLeft), .o_ctrlAluSel(o_ctrlAluSel), .o_ctrlAluOp(o_ctrlAluOp),
    .o_ctrlRegWr0(o_ctrlRegWr0), .o_ctrlRegWr1(o_ctrlRegWr1),
    .o_ctrlRegBusSel(o_ctrlRegBusSel), .o_ctrlRegBusEn(o_ctrlRegBusEn),
    .o_ctrlRamAddressEn(o_ctrlRamAddressEn), .o_ctrlRamWriteEn(o_ctrlRamWriteEn),
    .o_ctrlRamReadDataSelect(o_ctrlRamReadDataSelect), .o_ctrlRamOE(o_ctrlRamOE),
    .o_busImm(o_busImm), .o_busImmEn(o_busImmEn),
    .o_branchValid(o_branchValid), .o_branchTarget(o_branchTarget),
    .o_illegal(o_illegal), .o_halted(o_halted)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic       ready, aluOE, aluSub, aluBWr, aluShl, aluSel;
    logic [1:0] aluOp;
    logic       wr0, wr1, busSel, busEn, ramAddr, ramWr, ramRdSel, ramOE, immEn;
    logic [7:0] imm;
    logic       brValid;
    logic [7:0] brTarget;
    logic       illegal, halted;
  } obs_t;

  typedef struct {
    string       name;
    logic [15:0] instr;
    logic        fN, fZ;
    int unsigned n;
    obs_t        exp [3];
  } vec_t;

  vec_t vecs[$];
  obs_t expQ[$];

  function automatic obs_t getObs();
    obs_t o;
    o.ready = o_instrReady;  o.aluOE = o_ctrlAluOE;  o.aluSub = o_ctrlAluSub;
    o.aluBWr = o_ctrlAluBWr; o.aluShl = o_ctrlAluShiftLeft; o.aluSel = o_ctrlAluSel;
    o.aluOp = o_ctrlAluOp;   o.wr0 = o_ctrlRegWr0;   o.wr1 = o_ctrlRegWr1;
    o.busSel = o_ctrlRegBusSel; o.busEn = o_ctrlRegBusEn; o.ramAddr = o_ctrlRamAddressEn;
    o.ramWr = o_ctrlRamWriteEn; o.ramRdSel = o_ctrlRamReadDataSelect; o.ramOE = o_ctrlRamOE;
    o.immEn = o_busImmEn;    o.imm = o_busImm;       o.brValid = o_branchValid;
    o.brTarget = o_branchTarget; o.illegal = o_illegal; o.halted = o_halted;
    return o;
  endfunction

  function automatic obs_t eIdle();
    obs_t o = '0;
    o.ready = 1'b1;
    return o;
  endfunction

  function automatic obs_t eImm(logic rd, logic [7:0] imm);
    obs_t o = '0;
    o.immEn = 1'b1; o.imm = imm; o.wr0 = ~rd; o.wr1 = rd;
    return o;
  endfunction

  function automatic obs_t eBload(logic useImm, logic rb, logic [7:0] imm);
    obs_t o = '0;
    o.aluBWr = 1'b1;
    if (useImm) begin o.immEn = 1'b1; o.imm = imm; end
    else begin o.busSel = rb; o.busEn = 1'b1; end
    return o;
  endfunction

  function automatic obs_t eAlu(logic [1:0] op, logic sub, logic shl, logic sel, logic wb, logic rd);
    obs_t o = '0;
    o.aluOp = op; o.aluSub = sub; o.aluShl = shl; o.aluSel = sel;
    if (wb) begin o.aluOE = 1'b1; o.wr0 = ~rd; o.wr1 = rd; end
    return o;
  endfunction

  function automatic obs_t eMaddr(logic ra);
    obs_t o = '0;
    o.busSel = ra; o.busEn = 1'b1; o.ramAddr = 1'b1;
    return o;
  endfunction

  function automatic obs_t eMwr(logic rb);
    obs_t o = '0;
    o.busSel = rb; o.busEn = 1'b1; o.ramWr = 1'b1;
    return o;
  endfunction

  function automatic obs_t eMrd(logic rd);
    obs_t o = '0;
    o.ramRdSel = 1'b1; o.ramOE = 1'b1; o.wr0 = ~rd; o.wr1 = rd;
    return o;
  endfunction

  function automatic obs_t eBr(logic taken, logic [7:0] tgt);
    obs_t o = '0;
    o.brValid = taken; o.brTarget = tgt;
    return o;
  endfunction

  function automatic obs_t eFlag(logic ill, logic hlt);
    obs_t o = '0;
    o.illegal = ill; o.halted = hlt;
    return o;
  endfunction

  function automatic vec_t mkVec(string name, logic [15:0] instr, logic fN, logic fZ,
                                 int unsigned n, obs_t e0, obs_t e1, obs_t e2);
    vec_t v;
    v.name = name; v.instr = instr; v.fN = fN; v.fZ = fZ; v.n = n;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
    return v;
  endfunction

  // Non-strict checks ignore data values whose qualifying enable is expected low.
  task automatic check(input string name, input obs_t exp, input bit strict);
    obs_t act = getObs();
    obs_t e = exp;
    if (!strict) begin
      if (!e.immEn)   begin act.imm = '0;      e.imm = '0;      end
      if (!e.brValid) begin act.brTarget = '0; e.brTarget = '0; end
    end
    compared++;
    if (act !== e) begin
      mismatched++;
      $display("FAIL %s: actual=%h required=%h", name, act, e);
    end
  endtask

  task automatic runVec(input vec_t v);
    @(negedge i_clk);
    check({v.name, "_idle"}, eIdle(), 1'b0);
    i_instr = v.instr; i_instrValid = 1'b1;
    i_aluFlagN = v.fN; i_aluFlagZ = v.fZ;
    @(posedge i_clk);
    #1 i_instrValid = 1'b0;
    for (int unsigned k = 0; k < v.n; k++) expQ.push_back(v.exp[k]);
    for (int unsigned k = 0; k < v.n; k++) begin
      @(negedge i_clk);
      check($sformatf("%s_c%0d", v.name, k), expQ.pop_front(), 1'b0);
    end
  endtask

  task automatic runAll();
    while (vecs.size() > 0) runVec(vecs.pop_front());
  endtask

  always @(negedge i_clk) begin
    if (!i_reset) begin
      compared++;
      if ((o_ctrlRegWr0 && o_ctrlRegWr1) ||
          (int'(o_busImmEn) + int'(o_ctrlRegBusEn) + int'(o_ctrlAluOE) + int'(o_ctrlRamOE) > 1)) begin
        mismatched++;
        $display("FAIL invariant: wr0=%b wr1=%b immEn=%b busEn=%b aluOE=%b ramOE=%b required at most one",
                 o_ctrlRegWr0, o_ctrlRegWr1, o_busImmEn, o_ctrlRegBusEn, o_ctrlAluOE, o_ctrlRamOE);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t none = '0;
    i_reset = 1'b1; i_instrValid = 1'b0; i_instr = '0;
    i_aluFlagN = 1'b0; i_aluFlagZ = 1'b0;
    repeat (10) begin
      @(negedge i_clk);
      check("reset_hold", '0, 1'b1);
    end
    i_reset = 1'b0;
    #1 check("first_idle", eIdle(), 1'b1);

    vecs.push_back(mkVec("ldi",  16'h102A, 0, 0, 1, eImm(0, 8'h2A), none, none));
    vecs.push_back(mkVec("shr",  16'h6A01, 0, 1, 3, eBload(1, 0, 8'h01),
                         eAlu(2'b11, 0, 0, 0, 0, 0), eAlu(2'b11, 0, 0, 0, 1, 1)));
    vecs.push_back(mkVec("bz_t", 16'hA0A0, 1, 0, 1, eBr(1, 8'hA0), none, none));
    vecs.push_back(mkVec("bn_n", 16'hB055, 1, 1, 1, eBr(0, 8'h55), none, none));
    vecs.push_back(mkVec("add",  16'h2400, 1, 0, 3, eBload(0, 0, 8'h00),
                         eAlu(2'b00, 0, 0, 1, 0, 0), eAlu(2'b00, 0, 0, 1, 1, 0)));
    vecs.push_back(mkVec("bn_t", 16'hB033, 0, 1, 1, eBr(1, 8'h33), none, none));
    vecs.push_back(mkVec("bz_n", 16'hA011, 0, 1, 1, eBr(0, 8'h11), none, none));
    vecs.push_back(mkVec("sub",  16'h3B07, 0, 1, 3, eBload(1, 1, 8'h07),
                         eAlu(2'b00, 1, 0, 0, 0, 1), eAlu(2'b00, 1, 0, 0, 1, 1)));
    vecs.push_back(mkVec("and",  16'h4500, 0, 0, 3, eBload(0, 1, 8'h00),
                         eAlu(2'b01, 0, 0, 1, 0, 0), eAlu(2'b01, 0, 0, 1, 1, 0)));
    vecs.push_back(mkVec("or",   16'h5EF0, 1, 1, 3, eBload(1, 0, 8'hF0),
                         eAlu(2'b10, 0, 0, 1, 0, 1), eAlu(2'b10, 0, 0, 1, 1, 1)));
    vecs.push_back(mkVec("shl",  16'h7100, 0, 1, 3, eBload(0, 1, 8'h00),
                         eAlu(2'b11, 0, 1, 0, 0, 0), eAlu(2'b11, 0, 1, 0, 1, 0)));
    vecs.push_back(mkVec("st",   16'h8100, 1, 0, 2, eMaddr(0), eMwr(1), none));
    vecs.push_back(mkVec("ld",   16'h9000, 1, 0, 2, eMaddr(0), eMrd(0), none));
    vecs.push_back(mkVec("nop",  16'h0000, 1, 0, 0, none, none, none));
    vecs.push_back(mkVec("ld_r1", 16'h9C00, 1, 0, 2, eMaddr(1), eMrd(1), none));
    vecs.push_back(mkVec("bz_keep", 16'hA0A0, 0, 0, 1, eBr(1, 8'hA0), none, none));
    vecs.push_back(mkVec("bn_keep", 16'hB0FF, 1, 1, 1, eBr(0, 8'hFF), none, none));
    vecs.push_back(mkVec("ill_d", 16'hD123, 0, 0, 1, eFlag(1, 0), none, none));
    vecs.push_back(mkVec("ill_c", 16'hC000, 0, 0, 1, eFlag(1, 0), none, none));
    vecs.push_back(mkVec("ill_e", 16'hE000, 0, 0, 1, eFlag(1, 0), none, none));
    vecs.push_back(mkVec("sub_set", 16'h3B07, 1, 1, 3, eBload(1, 1, 8'h07),
                         eAlu(2'b00, 1, 0, 0, 0, 1), eAlu(2'b00, 1, 0, 0, 1, 1)));
    vecs.push_back(mkVec("bn_pre", 16'hB001, 0, 0, 1, eBr(1, 8'h01), none, none));
    runAll();

    // Reset asserted during EXEC of ADD: strobes clear at once, no WB later, flags cleared.
    @(negedge i_clk);
    i_instr = 16'h2400; i_instrValid = 1'b1; i_aluFlagN = 1'b1; i_aluFlagZ = 1'b1;
    @(posedge i_clk);
    #1 i_instrValid = 1'b0;
    expQ.push_back(eBload(0, 0, 8'h00));
    expQ.push_back(eAlu(2'b00, 0, 0, 1, 0, 0));
    @(negedge i_clk); check("rst_add_bload", expQ.pop_front(), 1'b0);
    @(negedge i_clk); check("rst_add_exec", expQ.pop_front(), 1'b0);
    #1 i_reset = 1'b1;
    #1 check("rst_async", '0, 1'b1);
    @(negedge i_clk);
    i_reset = 1'b0;
    #1 check("rst_release", eIdle(), 1'b1);
    @(negedge i_clk); check("rst_no_wb", eIdle(), 1'b0);
    vecs.push_back(mkVec("bz_clr", 16'hA0A0, 1, 1, 1, eBr(0, 8'hA0), none, none));
    vecs.push_back(mkVec("bn_clr", 16'hB0B0, 1, 1, 1, eBr(0, 8'hB0), none, none));
    runAll();

    // Halt with valid held high; only reset exits.
    @(negedge i_clk);
    check("hlt_idle", eIdle(), 1'b0);
    i_instr = 16'hF000; i_instrValid = 1'b1;
    @(posedge i_clk);
    repeat (20) begin
      @(negedge i_clk);
      check("halted", eFlag(0, 1), 1'b0);
    end
    #1 i_reset = 1'b1;
    #1 check("hlt_reset", '0, 1'b1);
    i_instrValid = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b0;
    #1 check("hlt_release", eIdle(), 1'b1);
    vecs.push_back(mkVec("ldi_after", 16'h1855, 0, 0, 1, eImm(1, 8'h55), none, none));
    runAll();
    @(negedge i_clk);
    check("final_idle", eIdle(), 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Micro-sequencer directly upstream of the datapath.
- Accepts one 16-bit instruction per handshake from the fetch stage.
- Drives every datapath control strobe cycle by cycle, and drives immediates onto the shared data bus.
- Captures the ALU N/Z flags after each ALU writeback and resolves conditional branches for fetch.

Parameters:
DATA_WIDTH, 8, data bus / immediate / branch target width; instruction width is DATA_WIDTH+8

Ports:
i_clk  in  1  clock, all state changes on posedge
i_reset  in  1  asynchronous, active-high reset
i_instr  in  16  [15:12] opcode, [11] rd, [10] ra (ALU A / address reg), [9] useImm, [8] rb, [7:0] imm
i_instrValid  in  1  fetch offers i_instr
o_instrReady  out  1  sequencer accepts i_instr this cycle
i_aluFlagN  in  1  datapath negative flag
i_aluFlagZ  in  1  datapath zero flag
o_ctrlAluOE, o_ctrlAluSub, o_ctrlAluBWr, o_ctrlAluShiftLeft, o_ctrlAluSel  out  1 each  ALU strobes
o_ctrlAluOp  out  2  00 add/sub, 01 and, 10 or, 11 shift
o_ctrlRegWr0, o_ctrlRegWr1, o_ctrlRegBusSel, o_ctrlRegBusEn  out  1 each  register-file strobes
o_ctrlRamAddressEn, o_ctrlRamWriteEn, o_ctrlRamReadDataSelect, o_ctrlRamOE  out  1 each  RAM strobes
o_busImm  out  DATA_WIDTH  immediate value for the bus
o_busImmEn  out  1  the bus tri-state driver drives o_busImm
o_branchValid  out  1  one-cycle pulse: branch taken
o_branchTarget  out  DATA_WIDTH  target; meaningful only while o_branchValid=1
o_illegal  out  1  one-cycle pulse: undefined opcode
o_halted  out  1  sequencer halted

Behaviour:
- Reset (async): state IDLE, IR=0, flagN=flagZ=0.
  - All control outputs, o_busImmEn, o_branchValid, o_illegal and o_halted are 0.
  - o_busImm=0. o_instrReady=0 while i_reset=1.
- Handshake:
  - o_instrReady=1 only in IDLE.
  - On posedge with valid&ready, i_instr is latched into IR and the FSM leaves IDLE.
  - Control outputs are decoded from state+IR only; they never depend on i_instrValid.
  - Everything not listed in a state is 0.
- Opcodes and state sequences (each state lasts 1 cycle, then IDLE follows):
  - 0x0 NOP: no state, stays in IDLE.
  - 0x1 LDI: IMM: busImmEn=1, busImm=imm, RegWr[rd]=1.
  - ALU ops: 0x2 ADD (op00), 0x3 SUB (op00, Sub=1), 0x4 AND (01), 0x5 OR (10), 0x6 SHR (11), 0x7 SHL (11, ShiftLeft=1). Sequence BLOAD -> EXEC -> WB.
    - BLOAD: AluBWr=1. If useImm, busImmEn=1; else RegBusSel=rb, RegBusEn=1.
    - EXEC: AluOp/Sub/ShiftLeft per opcode, AluSel=ra.
    - WB: same as EXEC plus AluOE=1 and RegWr[rd]=1. flagN/flagZ are sampled from i_aluFlagN/Z at the end of WB.
  - 0x8 ST [ra]=rb: MADDR -> MWR.
    - MADDR: RegBusSel=ra, RegBusEn, RamAddressEn.
    - MWR: RegBusSel=rb, RegBusEn, RamWriteEn.
  - 0x9 LD rd=[ra]: MADDR -> MRD.
    - MADDR: as for ST.
    - MRD: RamReadDataSelect, RamOE, RegWr[rd].
  - 0xA BZ / 0xB BN: BR. o_branchValid = flagZ / flagN respectively; o_branchTarget=imm. Flags are not modified.
  - 0xF HLT: HALT. o_halted=1, ready=0; exits only via reset.
  - 0xC-0xE illegal: ILL. o_illegal=1, executes as NOP.
- Latency from accept to return to IDLE: LDI/BR/ILL 1 cycle, ST/LD 2, ALU 3. The next instruction can be accepted the following cycle.
- Invariants:
  - RegWr0 and RegWr1 are never both 1.
  - busImmEn, RegBusEn, AluOE and RamOE are mutually exclusive; this is a single bus driver rule.
- Reset mid-sequence aborts immediately. No strobe may remain asserted after reset assertion. Flags clear.
- Flags persist across non-ALU instructions.

Decomposition:
- Package edic_ctrl_pkg holds:
  - opcode_t enum (4 bit);
  - state_t enum (IDLE, IMM, BLOAD, EXEC, WB, MADDR, MWR, MRD, BR, ILL, HALT);
  - ALU op constants ALU_ADD=2'b00, ALU_AND=2'b01, ALU_OR=2'b10, ALU_SHIFT=2'b11;
  - a ctrl_t packed struct bundling all strobes.
- One combinational sub-module, instr_decode: maps (state, IR) to ctrl_t.
- The top holds the FSM, IR, flags and handshake.

Test Plan:
- Reset held 10 cycles, then released -> all outputs 0 during reset; ready=1 on the first IDLE cycle.
- LDI r0,0x2A (0x102A) -> one cycle with busImmEn=1, busImm=0x2A, RegWr0=1, RegWr1=0; back in IDLE next cycle.
- SHR r1,r0,#1 (0x1A01 opcode 6 -> 0x6A01) -> BLOAD (busImmEn, busImm=0x01, AluBWr), then EXEC (AluOp=11, ShiftLeft=0, AluSel=0), then WB (+AluOE, RegWr1). Drive i_aluFlagZ=1 in WB -> a following BZ 0xA0 (0xA0A0) gives branchValid=1, target=0xA0.
- ST [r0]=r1 (0x8100) followed by LD r0=[r0] (0x9000):
  - ST cycles: {RegBusSel=0, RegBusEn, RamAddressEn}, then {RegBusSel=1, RegBusEn, RamWriteEn}.
  - LD cycles: address cycle, then {RamReadDataSelect, RamOE, RegWr0}.
  - Bus-exclusivity assertion holds on every cycle.
- Opcode 0xD -> o_illegal pulse of exactly 1 cycle. Then HLT 0xF000 -> o_halted=1, ready=0 indefinitely with valid held high; reset clears it.
- Assert i_reset during EXEC of ADD -> all strobes 0 within the same cycle (asynchronous); no WB occurs after release; flags=0.
